// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch front end: PC, pipelined IMEM requests, prefetch FIFO, redirect flush
module fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     INST_W     = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 32'h8000_0000,
  parameter logic [XLEN-1:0] IMEM_BASE  = 32'h8000_0000,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [XLEN-1:0]   inst_pc,
  output logic [XLEN-1:0]   inst_pc_plus4
);

  localparam int unsigned     AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned     CW      = AW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [INST_W-1:0] data_mem [FIFO_DEPTH];
  logic [XLEN-1:0]   pc_mem   [FIFO_DEPTH];

  logic [CW:0] credits_used;
  logic        req_fire;
  logic        rsp_drop;
  logic        push;
  logic        pop;

  // A request may only go out if its response is guaranteed a FIFO slot.
  assign credits_used   = {1'b0, outst_q} + {1'b0, cnt_q};
  assign imem_req_valid = rst && !redirect_valid && (credits_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q - IMEM_BASE;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses to requests issued before a redirect are stale and dropped.
  assign rsp_drop = imem_rsp_valid && (disc_q != '0);
  assign push     = imem_rsp_valid && (disc_q == '0) && !redirect_valid;

  assign inst_valid    = (cnt_q != '0);
  assign pop           = inst_valid && inst_ready && !redirect_valid;
  assign inst_out      = data_mem[rd_ptr_q];
  assign inst_pc       = pc_mem[rd_ptr_q];
  assign inst_pc_plus4 = inst_pc + PC_STEP;

  // Next-state for PCs, counters and FIFO pointers; redirect overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    disc_d     = disc_q - CW'(rsp_drop);
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + PC_STEP;
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      disc_d     = outst_d;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_VEC;
      rsp_pc_q   <= RESET_VEC;
      cnt_q      <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO payload storage; PCs are reconstructed in order rather than tagged.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rsp_data;
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomised-latency bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          npops = 0;
  int          nfires = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  logic [31:0] exp_pc = BASE;
  logic        mark_first = 1'b0;
  logic [31:0] first_pc = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  int          n0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic        fire;
    logic        pop;
    logic [31:0] a;
    req_t        r;
    @(negedge clk);
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    pop  = inst_valid && inst_ready && !redirect_valid && rst;
    if (pop) begin
      chk("pop_pc", inst_pc, exp_pc);
      chk("pop_data", inst_out, imem_word(exp_pc - BASE));
      chk("pop_pc4", inst_pc_plus4, exp_pc + 32'd4);
      if (mark_first) begin
        first_pc   = inst_pc;
        mark_first = 1'b0;
      end
      exp_pc = exp_pc + 32'd4;
      npops++;
    end
    if (redirect_valid && rst) exp_pc = {redirect_pc[31:2], 2'b00};
    if (fire) nfires++;
    prev_stall = imem_req_valid && !imem_req_ready;
    prev_addr  = a;
    @(posedge clk);
    cyc++;
    #1;
    if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
    if (fire) begin
      r.addr = a;
      r.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
      pend.push_back(r);
    end
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = imem_word(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    pend.delete();
    exp_pc = BASE;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    // reset held: nothing requested, nothing valid
    lat_lo = 0; lat_hi = 0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    repeat (2) tick();
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);

    // streaming from reset with 1-cycle latency
    rst = 1'b1;
    #1;
    chk("s0_req_valid", imem_req_valid, 1);
    chk("s0_addr", imem_req_addr, 32'h0);
    chk("s0_inst_valid", inst_valid, 0);
    tick(); #1;
    chk("s1_addr", imem_req_addr, 32'h4);
    chk("s1_inst_valid", inst_valid, 0);
    tick(); #1;
    chk("s2_addr", imem_req_addr, 32'h8);
    chk("s2_inst_valid", inst_valid, 1);
    chk("s2_inst_pc", inst_pc, BASE);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      chk("sustain_valid", inst_valid, 1);
    end

    // decode stalled: exactly FIFO_DEPTH requests, then in-order drain
    do_reset();
    inst_ready = 1'b0;
    nfires = 0;
    repeat (10) tick();
    #1;
    chk("full_fires", nfires, 4);
    chk("full_req_valid", imem_req_valid, 0);
    chk("full_inst_valid", inst_valid, 1);
    inst_ready = 1'b1;
    mark_first = 1'b1;
    n0 = npops;
    repeat (4) tick();
    chk("drain_pops", npops - n0, 4);
    chk("drain_first_pc", first_pc, BASE);

    // redirect with three requests in flight
    do_reset();
    lat_lo = 10; lat_hi = 10;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    #1;
    chk("redir_no_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    lat_lo = 0; lat_hi = 0;
    #1;
    chk("redir_inst_valid", inst_valid, 0);
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_addr", imem_req_addr, 32'h100);
    mark_first = 1'b1;
    n0 = npops;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      chk("redir_drop_valid", inst_valid, 0);
    end
    repeat (20) tick();
    chk("redir_first_pc", first_pc, 32'h8000_0100);
    chk("redir_progress", (npops - n0) > 5, 1);

    // redirect coinciding with a response and a ready decode
    #1;
    chk("coin_pre_valid", inst_valid, 1);
    chk("coin_pre_rsp", imem_rsp_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("coin_inst_valid", inst_valid, 0);
    chk("coin_addr", imem_req_addr, 32'h40);
    mark_first = 1'b1;
    repeat (10) tick();
    chk("coin_first_pc", first_pc, 32'h8000_0040);

    // PC below IMEM_BASE wraps the request address
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7fff_fffe;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", imem_req_addr, 32'hffff_fffc);
    mark_first = 1'b1;
    tick(); #1;
    chk("wrap_addr1", imem_req_addr, 32'h0);
    repeat (6) tick();
    chk("wrap_first_pc", first_pc, 32'h7fff_fffc);

    // random handshakes, latencies and redirects against the PC model
    n0 = npops;
    lat_lo = 0; lat_hi = 5;
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = $urandom_range(1, 0) != 0;
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = BASE + ($urandom & 32'h3ff);
      #1;
      if (imem_req_valid && prev_stall) chk("addr_stable", imem_req_addr, prev_addr);
      tick();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", (npops - n0) > 30, 1);

    // async reset mid-stream with a full FIFO
    lat_lo = 0; lat_hi = 0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    repeat (12) tick();
    #1;
    chk("pre_rst_full", inst_valid, 1);
    chk("pre_rst_req", imem_req_valid, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_inst_valid", inst_valid, 0);
    chk("mid_rst_req_valid", imem_req_valid, 0);
    pend.delete();
    imem_rsp_valid = 1'b0;
    exp_pc = BASE;
    repeat (2) tick();
    rst = 1'b1;
    inst_ready = 1'b1;
    mark_first = 1'b1;
    repeat (10) tick();
    chk("post_rst_first_pc", first_pc, BASE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
